// File: rtl/cursor_input.sv
// ---------------------------------------------------------------------------
// cursor_input -- front end that turns the four KEY pushbuttons into cursor
// moves on an 8x8 board.
//
// Each button goes through its own cursor_key lane, which does the
// synchronising, debouncing, press detection and auto-repeat. The top level
// registers the per-key move requests and steps the cursor row and column.
//
// Ports:
//   CLOCK_50    in   1  system clock
//   reset_n     in   1  asynchronous active-low reset
//   KEY         in   4  raw buttons, low = pressed: [3] left [2] right [1] up [0] down
//   dir_pulse   out  4  one-cycle move request per key, same bit order as KEY
//   move_valid  out  1  high whenever dir_pulse is nonzero
//   cursor_row  out  3  cursor row, 0 = top
//   cursor_col  out  3  cursor column, 0 = left
//   keys_held   out  4  debounced pressed state, 1 = held
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// cursor_key -- the processing for a single button.
//
//   clk, rst_n   clock and asynchronous active-low reset
//   key_raw      raw button level, low = pressed, asynchronous to clk
//   pulse_next   the move request that the top level registers on the next
//                edge (a press or an auto-repeat)
//   held         debounced pressed state, taken straight from a flop
// ---------------------------------------------------------------------------
module cursor_key #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw,
    output logic pulse_next,
    output logic held
);

    localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int HW   = $clog2(HMAX + 1);

    logic          sync1;
    logic          sync2;
    logic          stable;      // debounced level, 1 = released
    logic          stable_d;    // stable one edge later, used for flip detection
    logic [DW-1:0] db_cnt;
    logic [HW-1:0] hold_cnt;    // cycles since the last pulse while held
    logic          rep_phase;   // 0: waiting for the first repeat, 1: periodic

    logic          db_hit;
    logic          stable_next;
    logic          press;
    logic          holding;
    logic          fire;

    // The counter sits at DEBOUNCE_CYCLES-1 on the edge where it would reach
    // DEBOUNCE_CYCLES, so that edge flips the stable level instead.
    assign db_hit      = (sync2 != stable) && (db_cnt == DW'(DEBOUNCE_CYCLES - 1));
    assign stable_next = db_hit ? ~stable : stable;

    // The press pulse is the registered copy of the 1->0 flip.
    assign press = stable_d & ~stable;

    // Held past the press pulse and not being released on this edge; the
    // release guard stops a repeat from landing on the release flip itself.
    assign holding = ~stable_d & ~stable & ~stable_next;

    assign fire = (REPEAT_DELAY > 0) && holding &&
                  (hold_cnt == (rep_phase ? HW'(REPEAT_PERIOD) : HW'(REPEAT_DELAY)));

    assign pulse_next = press | fire;
    assign held       = ~stable;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            stable    <= 1'b1;
            stable_d  <= 1'b1;
            db_cnt    <= '0;
            hold_cnt  <= '0;
            rep_phase <= 1'b0;
        end else begin
            sync1    <= key_raw;
            sync2    <= sync1;
            stable   <= stable_next;
            stable_d <= stable;

            // Any cycle that agrees with the stable level restarts the count,
            // so only an unbroken run of DEBOUNCE_CYCLES disagreements flips it.
            if (sync2 == stable || db_hit)
                db_cnt <= '0;
            else
                db_cnt <= db_cnt + DW'(1);

            // hold_cnt counts cycles since the most recent pulse; loading 1 on
            // the pulse edge makes a match with N fire exactly N cycles later.
            if (press) begin
                hold_cnt  <= HW'(1);
                rep_phase <= 1'b0;
            end else if (!holding) begin
                hold_cnt  <= '0;
                rep_phase <= 1'b0;
            end else if (fire) begin
                hold_cnt  <= HW'(1);
                rep_phase <= 1'b1;
            end else begin
                hold_cnt  <= hold_cnt + HW'(1);
            end
        end
    end

endmodule

// ---------------------------------------------------------------------------
// cursor_input -- top level: four cursor_key lanes plus the cursor registers.
// ---------------------------------------------------------------------------
module cursor_input #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000,
    parameter int WRAP            = 1,
    parameter int RESET_ROW       = 7,
    parameter int RESET_COL       = 4
) (
    input  logic       CLOCK_50,
    input  logic       reset_n,
    input  logic [3:0] KEY,
    output logic [3:0] dir_pulse,
    output logic       move_valid,
    output logic [2:0] cursor_row,
    output logic [2:0] cursor_col,
    output logic [3:0] keys_held
);

    localparam int NUM_KEYS = 4;

    logic [NUM_KEYS-1:0] pulse_next;
    logic [NUM_KEYS-1:0] held;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        cursor_key #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_key (
            .clk        (CLOCK_50),
            .rst_n      (reset_n),
            .key_raw    (KEY[k]),
            .pulse_next (pulse_next[k]),
            .held       (held[k])
        );
    end

    assign keys_held = held;

    // One axis step. Opposite requests in the same cycle cancel; at the board
    // edge the position either wraps or holds depending on WRAP.
    function automatic logic [2:0] step(input logic [2:0] pos,
                                        input logic       dec,
                                        input logic       inc);
        logic [2:0] res;
        res = pos;
        if (inc && !dec) begin
            if (pos == 3'd7) res = (WRAP != 0) ? 3'd0 : 3'd7;
            else             res = pos + 3'd1;
        end else if (dec && !inc) begin
            if (pos == 3'd0) res = (WRAP != 0) ? 3'd7 : 3'd0;
            else             res = pos - 3'd1;
        end
        return res;
    endfunction

    // The cursor moves on the same edge that dir_pulse asserts, so both are
    // computed from pulse_next.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            dir_pulse  <= '0;
            move_valid <= 1'b0;
            cursor_row <= 3'(RESET_ROW);
            cursor_col <= 3'(RESET_COL);
        end else begin
            dir_pulse  <= pulse_next;
            move_valid <= |pulse_next;
            cursor_col <= step(cursor_col, pulse_next[3], pulse_next[2]);
            cursor_row <= step(cursor_row, pulse_next[1], pulse_next[0]);
        end
    end

endmodule
